regbank_access_ctrl: RTL and testbench
======================================

Name: regbank_access_ctrl

Overview:
Initiator side of the register bank. It accepts instructions from decode (rs1/rs2/rd), drives the regbank read ports A/B, and returns registered operands. It also arbitrates two writeback sources (LSU, ALU) onto the single regbank write port. A per-register busy scoreboard stalls issue on RAW/WAW hazards. It sits between decode, the execute stage and the regbank.

Parameters:
NUMREGS, 32, number of architectural registers
DATAWIDTH, 32, register data width
ADDRW, $clog2(NUMREGS)+1, register address width, matching regbank port widths; MSB must be 0 for valid indices

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
iss_valid_i  in  1  decode has an instruction
iss_ready_o  out  1  instruction accepted this cycle when both valid and ready are high
iss_rs1_i  in  ADDRW  source 1 index
iss_rs2_i  in  ADDRW  source 2 index
iss_rd_i  in  ADDRW  destination index
iss_rd_we_i  in  1  instruction writes rd
op_valid_o  out  1  operands valid
op_ready_i  in  1  execute accepts operands
op_a_o  out  DATAWIDTH  rs1 value
op_b_o  out  DATAWIDTH  rs2 value
op_rd_o  out  ADDRW  rd index
op_rd_we_o  out  1  rd write flag
re_a_o / raddr_a_o / rdata_a_i  out/out/in  1/ADDRW/DATAWIDTH  regbank port A
re_b_o / raddr_b_o / rdata_b_i  out/out/in  1/ADDRW/DATAWIDTH  regbank port B
we_o / waddr_o / wdata_o  out/out/out  1/ADDRW/DATAWIDTH  regbank write port
lsu_wb_valid_i, lsu_wb_ready_o, lsu_wb_rd_i, lsu_wb_data_i  in/out/in/in  1/1/ADDRW/DATAWIDTH  LSU writeback
alu_wb_valid_i, alu_wb_ready_o, alu_wb_rd_i, alu_wb_data_i  in/out/in/in  1/1/ADDRW/DATAWIDTH  ALU writeback

Behaviour:
- Writeback arbitration is fixed priority, LSU over ALU. lsu_wb_ready_o=1 always. alu_wb_ready_o=!lsu_wb_valid_i.
- we_o = winner valid. waddr_o and wdata_o come from the winner, combinationally.
- wb_clr[r] = we_o && waddr_o==r.
- busy[r] registers: reset to 0. A bit clears on wb_clr. It sets on an accepted issue with iss_rd_we_i and rd==r. When set and clear hit the same bit in the same cycle, set wins.
- hz(r) = busy[r] && !wb_clr[r]. Same-cycle writeback resolves the hazard because regbank forwards wdata to the read port.
- iss_ready_o = !hz(rs1) && !hz(rs2) && !(iss_rd_we_i && hz(rd)) && (!op_valid_o || op_ready_i). It is combinational.
- re_a_o = re_b_o = iss_valid_i && iss_ready_o. raddr_a_o = rs1 and raddr_b_o = rs2, driven directly.
- Latency is 1: on an accepted issue, op_a_o/op_b_o/op_rd_o/op_rd_we_o capture rdata/rd at the next posedge and op_valid_o goes to 1.
- op_valid_o clears on op_ready_i when no new issue is accepted in that cycle. If op_valid_o=1 and op_ready_i=0, outputs hold stable.
- A writeback to a non-busy register is still written; the scoreboard is unchanged.
- Reset, at any time including mid-operation, forces: op_valid_o=0, op_a_o/op_b_o/op_rd_o/op_rd_we_o=0, all busy=0. In-flight writebacks are discarded by their sources.
- Index MSB=1 is illegal; behaviour is undefined and covered by assertion only.

Optional Feature:
Macro: REGBANK_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writebacks with rd=0 are accepted (ready per arbitration) but we_o=0.
  - busy[0] is never set.
  - Reads of index 0 drive re_x_o=0, and op_x_o captures 0.
- Undefined: register 0 is an ordinary register with the same rules as the others.

Decomposition:
- Package regbank_pkg holds:
  - NUMREGS/DATAWIDTH defaults
  - the addr_t typedef (ADDRW bits)
  - a wb_req_t struct {valid, rd, data}
- One sub-module, regbank_scoreboard: busy vector with set/clear ports and hz lookups for three indices.

Test Plan:
- Issue rs1=3, rs2=4 with regbank r3=0x11, r4=0x22 -> one cycle later op_valid_o=1, op_a_o=0x11, op_b_o=0x22.
- Issue rd=5 (rd_we=1), then an instruction reading rs1=5 -> iss_ready_o=0 until the ALU writeback to rd=5, data 0xABCD. In that writeback cycle ready=1, and op_a_o=0xABCD next cycle.
- LSU and ALU writeback valid together (rd=6/0x1, rd=7/0x2) -> cycle 1: waddr_o=6, alu_wb_ready_o=0. Cycle 2: waddr_o=7, wdata_o=0x2.
- op_ready_i=0 with op_valid_o=1 -> iss_ready_o=0, and outputs hold for 3 cycles. Raising op_ready_i accepts the pending issue the same cycle.
- Assert rst_i with busy[9]=1 and op_valid_o=1 -> asynchronously op_valid_o=0 and busy cleared. After reset, issue rs1=9 is accepted immediately.
- With REGBANK_ZERO_REG_EN: writeback rd=0, data 0xFF -> we_o=0. Then issue rs1=0 -> op_a_o=0 and re_a_o=0.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths and writeback request type for the register bank access path
package regbank_pkg;
  localparam int NUMREGS = 32;
  localparam int DATAWIDTH = 32;
  localparam int ADDRW = $clog2(NUMREGS) + 1;
  typedef logic [ADDRW-1:0] addr_t;
  typedef logic [DATAWIDTH-1:0] data_t;
  typedef struct packed {
    logic  valid;
    addr_t rd;
    data_t data;
  } wb_req_t;
endpackage

// File: rtl/regbank_scoreboard.sv
// regbank_scoreboard: per-register busy bits with set/clear and hazard lookup for three indices
module regbank_scoreboard #(
  parameter int NUMREGS = regbank_pkg::NUMREGS,
  parameter int ADDRW = $clog2(NUMREGS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_en,
  input  logic [ADDRW-1:0] set_idx,
  input  logic             clr_en,
  input  logic [ADDRW-1:0] clr_idx,
  input  logic [ADDRW-1:0] idx_a,
  input  logic [ADDRW-1:0] idx_b,
  input  logic [ADDRW-1:0] idx_c,
  output logic             hz_a,
  output logic             hz_b,
  output logic             hz_c
);
  logic [NUMREGS-1:0] busy, set_vec, clr_vec, hz_vec;
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    hz_a = 1'b0;
    hz_b = 1'b0;
    hz_c = 1'b0;
    for (int r = 0; r < NUMREGS; r++) begin
      set_vec[r] = set_en && set_idx == ADDRW'(r);
      clr_vec[r] = clr_en && clr_idx == ADDRW'(r);
    end
    hz_vec = busy & ~clr_vec;
    for (int r = 0; r < NUMREGS; r++) begin
      hz_a = hz_a | (hz_vec[r] && idx_a == ADDRW'(r));
      hz_b = hz_b | (hz_vec[r] && idx_b == ADDRW'(r));
      hz_c = hz_c | (hz_vec[r] && idx_c == ADDRW'(r));
    end
  end
  // set is applied after clear so a same-cycle set wins
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) busy <= '0;
    else busy <= (busy & ~clr_vec) | set_vec;
endmodule

// File: rtl/regbank_access_ctrl.sv
// regbank_access_ctrl: issue/operand read, LSU>ALU writeback arbitration and RAW/WAW scoreboard
// REGBANK_ZERO_REG_EN: when defined, register 0 reads as zero and is never written or marked busy
module regbank_access_ctrl #(
  parameter int NUMREGS = regbank_pkg::NUMREGS,
  parameter int DATAWIDTH = regbank_pkg::DATAWIDTH,
  parameter int ADDRW = $clog2(NUMREGS) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 iss_valid_i,
  output logic                 iss_ready_o,
  input  logic [ADDRW-1:0]     iss_rs1_i,
  input  logic [ADDRW-1:0]     iss_rs2_i,
  input  logic [ADDRW-1:0]     iss_rd_i,
  input  logic                 iss_rd_we_i,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [DATAWIDTH-1:0] op_a_o,
  output logic [DATAWIDTH-1:0] op_b_o,
  output logic [ADDRW-1:0]     op_rd_o,
  output logic                 op_rd_we_o,
  output logic                 re_a_o,
  output logic [ADDRW-1:0]     raddr_a_o,
  input  logic [DATAWIDTH-1:0] rdata_a_i,
  output logic                 re_b_o,
  output logic [ADDRW-1:0]     raddr_b_o,
  input  logic [DATAWIDTH-1:0] rdata_b_i,
  output logic                 we_o,
  output logic [ADDRW-1:0]     waddr_o,
  output logic [DATAWIDTH-1:0] wdata_o,
  input  logic                 lsu_wb_valid_i,
  output logic                 lsu_wb_ready_o,
  input  logic [ADDRW-1:0]     lsu_wb_rd_i,
  input  logic [DATAWIDTH-1:0] lsu_wb_data_i,
  input  logic                 alu_wb_valid_i,
  output logic                 alu_wb_ready_o,
  input  logic [ADDRW-1:0]     alu_wb_rd_i,
  input  logic [DATAWIDTH-1:0] alu_wb_data_i
);
  import regbank_pkg::*;
  wb_req_t lsu_req, alu_req, win;
  logic hz_a, hz_b, hz_c, accept, set_en;
  logic [DATAWIDTH-1:0] a_in, b_in;
  assign lsu_req = '{valid: lsu_wb_valid_i, rd: lsu_wb_rd_i, data: lsu_wb_data_i};
  assign alu_req = '{valid: alu_wb_valid_i, rd: alu_wb_rd_i, data: alu_wb_data_i};
  assign win = lsu_req.valid ? lsu_req : alu_req;
  assign lsu_wb_ready_o = 1'b1;
  assign alu_wb_ready_o = !lsu_wb_valid_i;
  assign waddr_o = win.rd;
  assign wdata_o = win.data;
  assign raddr_a_o = iss_rs1_i;
  assign raddr_b_o = iss_rs2_i;
  assign iss_ready_o = !hz_a && !hz_b && !(iss_rd_we_i && hz_c) && (!op_valid_o || op_ready_i);
  assign accept = iss_valid_i && iss_ready_o;
`ifdef REGBANK_ZERO_REG_EN
  assign we_o = win.valid && win.rd != '0;
  assign set_en = accept && iss_rd_we_i && iss_rd_i != '0;
  assign re_a_o = accept && iss_rs1_i != '0;
  assign re_b_o = accept && iss_rs2_i != '0;
  assign a_in = iss_rs1_i == '0 ? '0 : rdata_a_i;
  assign b_in = iss_rs2_i == '0 ? '0 : rdata_b_i;
`else
  assign we_o = win.valid;
  assign set_en = accept && iss_rd_we_i;
  assign re_a_o = accept;
  assign re_b_o = accept;
  assign a_in = rdata_a_i;
  assign b_in = rdata_b_i;
`endif
  regbank_scoreboard #(.NUMREGS(NUMREGS), .ADDRW(ADDRW)) u_sb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .set_en (set_en),
    .set_idx(iss_rd_i),
    .clr_en (we_o),
    .clr_idx(waddr_o),
    .idx_a  (iss_rs1_i),
    .idx_b  (iss_rs2_i),
    .idx_c  (iss_rd_i),
    .hz_a   (hz_a),
    .hz_b   (hz_b),
    .hz_c   (hz_c)
  );
  // regbank read ports are combinational, so operands are captured on the accepting edge
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      op_valid_o <= 1'b0;
      op_a_o <= '0;
      op_b_o <= '0;
      op_rd_o <= '0;
      op_rd_we_o <= 1'b0;
    end else if (accept) begin
      op_valid_o <= 1'b1;
      op_a_o <= a_in;
      op_b_o <= b_in;
      op_rd_o <= iss_rd_i;
      op_rd_we_o <= iss_rd_we_i;
    end else if (op_ready_i) begin
      op_valid_o <= 1'b0;
    end
  a_iss_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    iss_valid_i |-> !(iss_rs1_i[ADDRW-1] || iss_rs2_i[ADDRW-1] || iss_rd_i[ADDRW-1]));
  a_lsu_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    lsu_wb_valid_i |-> !lsu_wb_rd_i[ADDRW-1]);
  a_alu_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    alu_wb_valid_i |-> !alu_wb_rd_i[ADDRW-1]);
endmodule

// File: tb/tb_regbank_access_ctrl.sv
// tb_regbank_access_ctrl: scoreboard bench with a behavioural regbank that forwards same-cycle writes
module tb_regbank_access_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic iss_valid = 1'b0, iss_rd_we = 1'b0, op_ready = 1'b1;
  logic [5:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic iss_ready_o, op_valid_o, op_rd_we_o, re_a_o, re_b_o, we_o;
  logic [31:0] op_a_o, op_b_o, rdata_a, rdata_b, wdata_o;
  logic [5:0] op_rd_o, raddr_a_o, raddr_b_o, waddr_o;
  logic lsu_valid = 1'b0, alu_valid = 1'b0, lsu_wb_ready_o, alu_wb_ready_o;
  logic [5:0] lsu_rd = '0, alu_rd = '0;
  logic [31:0] lsu_data = '0, alu_data = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  rd;
    logic        we;
  } exp_t;
  exp_t exp_q[$];
  exp_t got;
  logic [31:0] rf [32];
  bit [31:0] wr_mask;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_val(input logic [4:0] i);
    return i == 0 ? 32'hDEAD0000 : i == 3 ? 32'h11 : i == 4 ? 32'h22 : 32'h100 + 32'(i);
  endfunction

  always @(posedge clk_i)
    if (we_o) begin
      rf[waddr_o[4:0]] <= wdata_o;
      wr_mask[waddr_o[4:0]] <= 1'b1;
    end
  assign rdata_a = (we_o && waddr_o == raddr_a_o) ? wdata_o :
                   wr_mask[raddr_a_o[4:0]] ? rf[raddr_a_o[4:0]] : init_val(raddr_a_o[4:0]);
  assign rdata_b = (we_o && waddr_o == raddr_b_o) ? wdata_o :
                   wr_mask[raddr_b_o[4:0]] ? rf[raddr_b_o[4:0]] : init_val(raddr_b_o[4:0]);

  regbank_access_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iss_valid_i(iss_valid), .iss_ready_o(iss_ready_o),
    .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .iss_rd_i(iss_rd), .iss_rd_we_i(iss_rd_we),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_rd_o(op_rd_o), .op_rd_we_o(op_rd_we_o),
    .re_a_o(re_a_o), .raddr_a_o(raddr_a_o), .rdata_a_i(rdata_a),
    .re_b_o(re_b_o), .raddr_b_o(raddr_b_o), .rdata_b_i(rdata_b),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .lsu_wb_valid_i(lsu_valid), .lsu_wb_ready_o(lsu_wb_ready_o),
    .lsu_wb_rd_i(lsu_rd), .lsu_wb_data_i(lsu_data),
    .alu_wb_valid_i(alu_valid), .alu_wb_ready_o(alu_wb_ready_o),
    .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_data)
  );

  // execute-side consumer: every completed operand handshake is matched against the queue
  always @(negedge clk_i)
    if (!rst_i && op_valid_o && op_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL op_unexpected got a=%h b=%h rd=%0d", op_a_o, op_b_o, op_rd_o);
      end else begin
        got = exp_q.pop_front();
        if ({op_a_o, op_b_o, op_rd_o, op_rd_we_o} !== {got.a, got.b, got.rd, got.we}) begin
          errors++;
          $display("FAIL op_result got a=%h b=%h rd=%0d we=%0b exp a=%h b=%h rd=%0d we=%0b",
                   op_a_o, op_b_o, op_rd_o, op_rd_we_o, got.a, got.b, got.rd, got.we);
        end
      end
    end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [5:0] s1, s2, d, input logic w,
                       input logic [31:0] ea, eb, input bit push);
    iss_valid = 1'b1;
    iss_rs1 = s1;
    iss_rs2 = s2;
    iss_rd = d;
    iss_rd_we = w;
    if (push) exp_q.push_back('{a: ea, b: eb, rd: d, we: w});
  endtask

  task automatic idle(input int n);
    iss_valid = 1'b0;
    iss_rd_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    repeat (2) tick();
    #2;
    checks++;
    if ({op_valid_o, op_a_o, op_b_o, op_rd_o, op_rd_we_o} !== '0) begin
      errors++;
      $display("FAIL reset_ops got v=%0b a=%h b=%h rd=%0d exp all zero", op_valid_o, op_a_o, op_b_o, op_rd_o);
    end
    checks++;
    if ({iss_ready_o, we_o, lsu_wb_ready_o, alu_wb_ready_o} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 1011", {iss_ready_o, we_o, lsu_wb_ready_o, alu_wb_ready_o});
    end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_read;
    issue(3, 4, 1, 0, 32'h11, 32'h22, 1);
    #2;
    checks++;
    if ({iss_ready_o, re_a_o, re_b_o, raddr_a_o, raddr_b_o} !== {3'b111, 6'd3, 6'd4}) begin
      errors++;
      $display("FAIL read_ports got rdy=%0b re=%0b%0b ra=%0d rb=%0d exp 1 11 3 4",
               iss_ready_o, re_a_o, re_b_o, raddr_a_o, raddr_b_o);
    end
    tick();
    iss_valid = 1'b0;
    #2;
    checks++;
    if ({op_valid_o, op_a_o, op_b_o} !== {1'b1, 32'h11, 32'h22}) begin
      errors++;
      $display("FAIL read_latency got v=%0b a=%h b=%h exp 1 11 22", op_valid_o, op_a_o, op_b_o);
    end
    idle(2);
  endtask

  task automatic test_raw;
    issue(1, 2, 5, 1, 32'h101, 32'h102, 1);
    #2;
    checks++;
    if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL raw_first_ready got %0b exp 1", iss_ready_o); end
    tick();
    issue(5, 2, 8, 0, 32'hABCD, 32'h102, 1);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (iss_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall got %0b exp 0", iss_ready_o); end
      tick();
    end
    alu_valid = 1'b1;
    alu_rd = 5;
    alu_data = 32'hABCD;
    #2;
    checks++;
    if ({iss_ready_o, we_o, waddr_o} !== {2'b11, 6'd5}) begin
      errors++;
      $display("FAIL raw_wb_release got rdy=%0b we=%0b waddr=%0d exp 1 1 5", iss_ready_o, we_o, waddr_o);
    end
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b0;
    #2;
    checks++;
    if (op_a_o !== 32'hABCD) begin errors++; $display("FAIL raw_forward got %h exp abcd", op_a_o); end
    idle(2);
  endtask

  task automatic test_wb_arb;
    lsu_valid = 1'b1; lsu_rd = 6; lsu_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h2;
    #2;
    checks++;
    if ({we_o, waddr_o, wdata_o, lsu_wb_ready_o, alu_wb_ready_o} !== {1'b1, 6'd6, 32'h1, 2'b10}) begin
      errors++;
      $display("FAIL arb_lsu_wins got we=%0b wa=%0d wd=%h rdy=%0b%0b exp 1 6 1 10",
               we_o, waddr_o, wdata_o, lsu_wb_ready_o, alu_wb_ready_o);
    end
    tick();
    lsu_valid = 1'b0;
    #2;
    checks++;
    if ({we_o, waddr_o, wdata_o, alu_wb_ready_o} !== {1'b1, 6'd7, 32'h2, 1'b1}) begin
      errors++;
      $display("FAIL arb_alu_next got we=%0b wa=%0d wd=%h rdy=%0b exp 1 7 2 1",
               we_o, waddr_o, wdata_o, alu_wb_ready_o);
    end
    tick();
    alu_valid = 1'b0;
    issue(6, 7, 0, 0, 32'h1, 32'h2, 1);
    #2;
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL arb_idle_we got %0b exp 0", we_o); end
    tick();
    idle(2);
  endtask

  task automatic test_backpressure;
    op_ready = 1'b0;
    issue(3, 4, 10, 1, 32'h11, 32'h22, 1);
    tick();
    issue(1, 2, 11, 0, 32'h101, 32'h102, 1);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if ({iss_ready_o, op_valid_o, op_a_o, op_b_o, op_rd_o} !== {2'b01, 32'h11, 32'h22, 6'd10}) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%0b v=%0b a=%h b=%h rd=%0d exp 0 1 11 22 10",
                 i, iss_ready_o, op_valid_o, op_a_o, op_b_o, op_rd_o);
      end
      tick();
    end
    op_ready = 1'b1;
    #2;
    checks++;
    if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", iss_ready_o); end
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 10; alu_data = 32'h55;
    #2;
    checks++;
    if ({op_valid_o, op_a_o, op_rd_o} !== {1'b1, 32'h101, 6'd11}) begin
      errors++;
      $display("FAIL bp_next got v=%0b a=%h rd=%0d exp 1 101 11", op_valid_o, op_a_o, op_rd_o);
    end
    tick();
    alu_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_async_reset;
    op_ready = 1'b0;
    issue(1, 2, 9, 1, 0, 0, 0);
    tick();
    iss_valid = 1'b0;
    #2;
    checks++;
    if (op_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b exp 1", op_valid_o); end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if ({op_valid_o, op_a_o, op_rd_o, op_rd_we_o} !== '0) begin
      errors++;
      $display("FAIL areset_async got v=%0b a=%h rd=%0d we=%0b exp zeros", op_valid_o, op_a_o, op_rd_o, op_rd_we_o);
    end
    iss_rs1 = 9; iss_rs2 = 2; iss_rd = 12; iss_rd_we = 1'b0;
    #1;
    checks++;
    if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL areset_busy got rdy=%0b exp 1", iss_ready_o); end
    tick();
    rst_i = 1'b0;
    op_ready = 1'b1;
    issue(9, 2, 12, 0, 32'h109, 32'h102, 1);
    #2;
    checks++;
    if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL areset_issue got %0b exp 1", iss_ready_o); end
    tick();
    iss_valid = 1'b0;
    #2;
    checks++;
    if (op_a_o !== 32'h109) begin errors++; $display("FAIL areset_op got %h exp 109", op_a_o); end
    idle(2);
  endtask

  task automatic test_zero_reg;
    lsu_valid = 1'b1; lsu_rd = 0; lsu_data = 32'hFF;
    #2;
`ifdef REGBANK_ZERO_REG_EN
    checks++;
    if ({we_o, lsu_wb_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL zero_wb got we=%0b rdy=%0b exp 0 1", we_o, lsu_wb_ready_o);
    end
    tick();
    lsu_valid = 1'b0;
    issue(0, 4, 0, 1, 32'h0, 32'h22, 1);
    #2;
    checks++;
    if ({iss_ready_o, re_a_o, re_b_o} !== 3'b101) begin
      errors++;
      $display("FAIL zero_read got rdy=%0b re=%0b%0b exp 1 01", iss_ready_o, re_a_o, re_b_o);
    end
    tick();
    issue(0, 0, 13, 0, 32'h0, 32'h0, 1);
    #2;
    checks++;
    if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL zero_not_busy got %0b exp 1", iss_ready_o); end
    tick();
    iss_valid = 1'b0;
    #2;
    checks++;
    if ({op_a_o, op_b_o, op_rd_o} !== {64'h0, 6'd13}) begin
      errors++;
      $display("FAIL zero_op got a=%h b=%h rd=%0d exp 0 0 13", op_a_o, op_b_o, op_rd_o);
    end
`else
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 6'd0, 32'hFF}) begin
      errors++;
      $display("FAIL r0_wb got we=%0b wa=%0d wd=%h exp 1 0 ff", we_o, waddr_o, wdata_o);
    end
    tick();
    lsu_valid = 1'b0;
    issue(0, 4, 0, 0, 32'hFF, 32'h22, 1);
    #2;
    checks++;
    if ({iss_ready_o, re_a_o} !== 2'b11) begin
      errors++;
      $display("FAIL r0_read got rdy=%0b re=%0b exp 1 1", iss_ready_o, re_a_o);
    end
    tick();
    iss_valid = 1'b0;
    #2;
    checks++;
    if (op_a_o !== 32'hFF) begin errors++; $display("FAIL r0_op got %h exp ff", op_a_o); end
`endif
    idle(2);
  endtask

  task automatic test_back_to_back;
    logic [5:0] s1 [4] = '{1, 3, 6, 2};
    logic [5:0] s2 [4] = '{2, 4, 7, 1};
    logic [31:0] ea [4] = '{32'h101, 32'h11, 32'h1, 32'h102};
    logic [31:0] eb [4] = '{32'h102, 32'h22, 32'h2, 32'h101};
    for (int i = 0; i < 4; i++) begin
      issue(s1[i], s2[i], 6'(20 + i), 0, ea[i], eb[i], 1);
      #2;
      checks++;
      if (iss_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %0b exp 1", i, iss_ready_o); end
      tick();
    end
    idle(3);
    checks++;
    if (op_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%0b exp 0", op_valid_o); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_raw();
    test_wb_arb();
    test_backpressure();
    test_async_reset();
    test_zero_reg();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1);
  end
endmodule
